// File: rtl/psum_deskew_unloader.sv
// Deskews the per-column south psums of the PE array into aligned N_COLS-wide vectors and buffers them in a FIFO.
// Latency: lane 0 in cycle t -> out_valid in cycle t+N_COLS. Backpressure: none toward the array; vectors arriving at a full FIFO are dropped (sticky overflow).
// Optional feature: define PSUM_DESKEW_RELU_EN to zero any lane with its sign bit set at the FIFO write point.
module psum_deskew_unloader #(
    parameter int DATA_WIDTH = 32,
    parameter int N_COLS     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic [N_COLS*DATA_WIDTH-1:0]       col_psum_in,
    input  logic [N_COLS-1:0]                  col_valid_in,
    output logic [N_COLS*DATA_WIDTH-1:0]       out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               almost_full,
    output logic                               overflow,
    output logic                               align_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int VW = N_COLS*DATA_WIDTH;

    logic                  al_vld [N_COLS];
    logic [DATA_WIDTH-1:0] al_dat [N_COLS];

    // Lane c is delayed N_COLS-1-c cycles so every lane meets the last column.
    for (genvar c = 0; c < N_COLS; c++) begin : g_lane
        if (c == N_COLS-1) begin : g_direct
            assign al_vld[c] = col_valid_in[c];
            assign al_dat[c] = col_psum_in[c*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_delay
            localparam int D = N_COLS-1-c;
            logic                  sv [D];
            logic [DATA_WIDTH-1:0] sd [D];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) begin
                        sv[i] <= 1'b0;
                        sd[i] <= '0;
                    end
                end else if (clear) begin
                    for (int i = 0; i < D; i++) begin
                        sv[i] <= 1'b0;
                        sd[i] <= '0;
                    end
                end else begin
                    sv[0] <= col_valid_in[c];
                    sd[0] <= col_psum_in[c*DATA_WIDTH +: DATA_WIDTH];
                    for (int i = 1; i < D; i++) begin
                        sv[i] <= sv[i-1];
                        sd[i] <= sd[i-1];
                    end
                end
            end

            assign al_vld[c] = sv[D-1];
            assign al_dat[c] = sd[D-1];
        end
    end

    logic [VW-1:0] wr_vec;
    logic          lane_mis;

    always_comb begin
        wr_vec   = '0;
        lane_mis = 1'b0;
        for (int c = 0; c < N_COLS; c++) begin
            if (al_vld[c]) begin
                wr_vec[c*DATA_WIDTH +: DATA_WIDTH] = al_dat[c];
            end
`ifdef PSUM_DESKEW_RELU_EN
            if (al_dat[c][DATA_WIDTH-1]) begin
                wr_vec[c*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
`endif
            if (al_vld[c] != al_vld[0]) begin
                lane_mis = 1'b1;
            end
        end
    end

    logic [VW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          wr_req;
    logic          wr_en;
    logic          rd_en;

    assign wr_req = al_vld[0];
    assign full   = (count == CW'(FIFO_DEPTH));
    assign rd_en  = out_valid & out_ready;
    // A read in the same cycle frees the slot the write needs, even at full.
    assign wr_en  = wr_req & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr] <= wr_vec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            align_err <= 1'b0;
        end else if (clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= overflow | (wr_req & full & ~rd_en);
            align_err <= align_err | lane_mis;
        end
    end

    assign out_valid   = (count != '0);
    assign out_data    = out_valid ? mem[rd_ptr] : '0;
    assign fifo_count  = count;
    assign almost_full = (count >= CW'(FIFO_DEPTH - N_COLS));

endmodule

// File: doc/psum_deskew_unloader.md
# psum_deskew_unloader

Sits directly below the bottom row of the systolic PE array and captures the FP32 partial sums leaving each column's south edge. Column c's k-th result emerges c cycles after column 0's k-th result because activations and valid ripple west-to-east one PE per cycle. This block removes that skew so the lanes line up again, and assembles each aligned set into one N_COLS-wide result vector. Vectors are buffered in a FIFO and handed to the downstream consumer (accumulator/writeback) over a valid/ready handshake.

## Interface
- DATA_WIDTH, 32: width of one FP32 lane.
- N_COLS, 4: number of array columns (≥2).
- FIFO_DEPTH, 8: result vectors buffered; power of two, ≥ N_COLS.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of delay lines, FIFO and sticky flags.
- col_psum_in  in  N_COLS*DATA_WIDTH  south psum of bottom-row PE per column; lane c = bits [c*DATA_WIDTH +: DATA_WIDTH].
- col_valid_in  in  N_COLS  south valid per column (bottom-row pe_valid_out), lane c = bit c.
- out_data  out  N_COLS*DATA_WIDTH  FIFO head vector, same lane packing as col_psum_in.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  vectors currently stored.
- almost_full  out  1  fifo_count ≥ FIFO_DEPTH − N_COLS.
- overflow  out  1  sticky: an aligned vector was dropped because the FIFO was full.
- align_err  out  1  sticky: lane valids disagreed at the alignment point.

## Operation
- Deskew: lane c passes through a shift register of N_COLS−1−c stages carrying {valid, data}. Lane N_COLS−1 has zero stages and is used directly. Every stage shifts every cycle; there is no stall, because the array cannot be back-pressured.
- Aligned write enable: wr = delayed valid of lane 0.
- Aligned vector: lane c = delayed data if delayed valid c is set, else 0.
- align_err is set in any cycle where some delayed lane valid ≠ delayed lane-0 valid. The vector is still written per the wr rule.
- FIFO: circular buffer with rd/wr pointers of $clog2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus a separate count.
  - Write when wr & (not full, or a read occurs in the same cycle).
  - Read when out_valid & out_ready.
- Full with wr and no read: the vector is dropped, overflow is set, and FIFO contents are unchanged.
- Simultaneous read and write: both occur. Count is unchanged, including at full. At empty, the write completes and the read does not occur (out_valid was 0).
- out_data is the head entry when out_valid = 1 and all zeros when empty.
- clear has priority over everything in the same cycle. Pointers, count and all delay stages go to 0; overflow and align_err go to 0; any in-cycle write or read is discarded.

## Timing
- Reset values: out_data 0, out_valid 0, fifo_count 0, almost_full 0, overflow 0, align_err 0. All delay stages and pointers are 0.
- Latency: lane 0 presented in cycle t and lane c in cycle t+c → vector is written at the edge ending cycle t+N_COLS−1 → out_valid = 1 in cycle t+N_COLS.
- Throughput: one vector per cycle in and out sustained.
- fifo_count, almost_full, out_valid and out_data update registered, at the edge of the write/read.
- Sticky flags set at the edge after the triggering cycle and hold until clear or reset.
- rst_n asserted mid-operation: all state clears immediately (asynchronously). Vectors still in flight in the delay lines are lost.

## Configuration
- PSUM_DESKEW_RELU_EN defined: ReLU is applied to each lane at the FIFO write point. Any lane whose sign bit (bit DATA_WIDTH−1) is 1 is written as 0. This covers −0.0, negative values, −Inf and NaNs with the sign bit set.
- Not defined: lanes are written bit-exact.

## Test plan
- Single skewed vector (N_COLS=4): lane c valid in cycle c with data 0x3F800000+c, others invalid → out_valid first high at cycle 4, out_data lanes = 0x3F800000..0x3F800003, fifo_count 1.
- Streaming 20 vectors with out_ready=1 → 20 outputs in order, one per cycle, no gaps after initial latency, overflow 0.
- out_ready=0, 10 vectors → fifo_count saturates at 8, almost_full from count 4, overflow=1, and after draining exactly vectors 0–7 are received.
- Full FIFO, out_ready=1 with a new write in the same cycle → count stays 8, and read order continues correctly across pointer wrap.
- Lane 2 valid missing on one vector → align_err=1, that vector's lane 2 = 0. Then clear → flags 0, out_valid 0, fifo_count 0.
- With PSUM_DESKEW_RELU_EN: lanes 0xBF800000, 0x80000000, 0x40000000, 0xFFC00000 → output 0, 0, 0x40000000, 0. Without the macro: output is bit-exact.
